// File: rtl/cnt12_disp.sv
// rtl/cnt12_disp.sv - mod-12 counter display, wrap detector and illegal-code monitor
//
// Purpose:
//   Samples the count from a mod-12 up/down counter and converts it to two BCD digits.
//   Drives a time-multiplexed, active-low, 2-digit 7-segment display.
//   Pulses on wrap events and keeps a modular wrap tally.
//   Flags illegal counter codes (12..15) with a sticky error bit.
//
// Optional feature macro: CNT12_DISP_LEADZERO_EN
//   When defined, a tens digit of 0 shows glyph 0 instead of blank.
//
// Ports:
//   clk      in   1       system clock, rising edge
//   reset    in   1       synchronous active-low reset
//   q_in     in   4       count from the mod-12 counter (0..11 legal)
//   ud_in    in   1       counter direction, 1 = up, 0 = down
//   seg      out  7       segments {g,f,e,d,c,b,a}, active-low
//   an       out  2       digit enables, active-low; an[0] = units, an[1] = tens
//   wrap_up  out  1       one-cycle pulse on an 11->0 transition counting up
//   wrap_dn  out  1       one-cycle pulse on a 0->11 transition counting down
//   wraps    out  WRAP_W  modular wrap tally (+1 up wrap, -1 down wrap)
//   err      out  1       sticky illegal-code flag

module cnt12_disp #(
  parameter int REFRESH_DIV = 50000,
  parameter int WRAP_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q_in,
  input  logic              ud_in,
  output logic [6:0]        seg,
  output logic [1:0]        an,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] wraps,
  output logic              err
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [3:0] Q_MAX = 4'd11;

  typedef enum logic {
    DIG0,
    DIG1
  } mux_state_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Sample register and wrap / error tracking
  // ---------------------------------------------------------------------------
  logic [3:0] q_r;
  logic       prev_valid;
  logic       up_hit;
  logic       dn_hit;

  // prev_valid qualifies q_r as a real, legal previous sample.
  // There is no detection on the first sample after reset or right after an illegal code.
  // The two hits need different q_r values, so they are mutually exclusive.
  always_comb begin
    up_hit = prev_valid && (q_r == Q_MAX) && (q_in == 4'd0) &&  ud_in;
    dn_hit = prev_valid && (q_r == 4'd0)  && (q_in == Q_MAX) && !ud_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r        <= 4'd0;
      prev_valid <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      wraps      <= '0;
      err        <= 1'b0;
    end else begin
      q_r        <= q_in;
      prev_valid <= (q_in <= Q_MAX);
      wrap_up    <= up_hit;
      wrap_dn    <= dn_hit;
      // The tally moves on the same edge that raises the pulse; overflow and underflow wrap naturally.
      if (up_hit) begin
        wraps <= wraps + WRAP_W'(1);
      end else if (dn_hit) begin
        wraps <= wraps - WRAP_W'(1);
      end
      if (q_in > Q_MAX) begin
        err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCD split and glyph selection
  // ---------------------------------------------------------------------------
  logic       illegal;
  logic       tens;
  logic [3:0] units;
  logic [6:0] units_glyph;
  logic [6:0] tens_glyph;

  always_comb begin
    illegal = (q_r > Q_MAX);
    tens    = (q_r >= 4'd10);
    units   = tens ? (q_r - 4'd10) : q_r;

    if (illegal) begin
      units_glyph = SEG_DASH;
      tens_glyph  = SEG_DASH;
    end else begin
      units_glyph = glyph(units);
      if (tens) begin
        tens_glyph = glyph(4'd1);
      end else begin
`ifdef CNT12_DISP_LEADZERO_EN
        tens_glyph = glyph(4'd0);
`else
        tens_glyph = SEG_BLANK;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display multiplex FSM
  // ---------------------------------------------------------------------------
  mux_state_t       state;
  mux_state_t       state_nxt;
  logic [CNT_W-1:0] refresh_cnt;
  logic [CNT_W-1:0] refresh_cnt_nxt;
  logic [6:0]       seg_nxt;
  logic [1:0]       an_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= DIG0;
      refresh_cnt <= '0;
      seg         <= SEG_BLANK;
      an          <= 2'b11;
    end else begin
      state       <= state_nxt;
      refresh_cnt <= refresh_cnt_nxt;
      seg         <= seg_nxt;
      an          <= an_nxt;
    end
  end

  // The outputs load from the current state, so each digit stays lit for REFRESH_DIV edges.
  // This also means the first edge after reset release loads the DIG0 outputs.
  always_comb begin
    state_nxt       = state;
    refresh_cnt_nxt = refresh_cnt + CNT_W'(1);
    seg_nxt         = SEG_BLANK;
    an_nxt          = 2'b11;

    if (refresh_cnt == CNT_LAST) begin
      refresh_cnt_nxt = '0;
      state_nxt       = (state == DIG0) ? DIG1 : DIG0;
    end

    case (state)
      DIG0: begin
        an_nxt  = 2'b10;
        seg_nxt = units_glyph;
      end
      DIG1: begin
        an_nxt  = 2'b01;
        seg_nxt = tens_glyph;
      end
      default: begin
        an_nxt  = 2'b11;
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_cnt12_disp.sv
// tb/tb_cnt12_disp.sv - self-checking bench for cnt12_disp with a behavioural model
module tb_cnt12_disp;

  localparam int RDIV = 4;
  localparam int WW   = 4;

`ifdef CNT12_DISP_LEADZERO_EN
  localparam logic [6:0] TENS0 = 7'b1000000;
`else
  localparam logic [6:0] TENS0 = 7'b1111111;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    q_in;
  logic          ud_in;
  logic [6:0]    seg;
  logic [1:0]    an;
  logic          wrap_up;
  logic          wrap_dn;
  logic [WW-1:0] wraps;
  logic          err;

  cnt12_disp #(.REFRESH_DIV(RDIV), .WRAP_W(WW)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .ud_in(ud_in),
    .seg(seg), .an(an), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .wraps(wraps), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: display phase derives from the edge count since release.
  logic [6:0] gl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bit            started = 0;
  int            m_qr, m_n;
  bit            m_pv, m_wu, m_wd, m_err;
  logic [WW-1:0] m_wraps;
  logic [6:0]    m_seg;
  logic [1:0]    m_an;

  function automatic logic [6:0] m_disp(input int qr, input int digit);
    int d;
    if (qr >= 12) return 7'b0111111;
    d = digit ? qr / 10 : qr % 10;
    if (digit && d == 0) return TENS0;
    return gl[d];
  endfunction

  task automatic model_update();
    int digit;
    if (!reset) begin
      m_qr = 0; m_pv = 0; m_wu = 0; m_wd = 0; m_err = 0;
      m_wraps = '0; m_seg = 7'h7F; m_an = 2'b11; m_n = 0;
    end else begin
      m_n++;
      digit = ((m_n - 1) / RDIV) % 2;
      m_an  = digit ? 2'b01 : 2'b10;
      m_seg = m_disp(m_qr, digit);
      m_wu  = m_pv && m_qr == 11 && q_in == 0 && ud_in;
      m_wd  = m_pv && m_qr == 0 && q_in == 11 && !ud_in;
      m_wraps = m_wraps + WW'(m_wu) - WW'(m_wd);
      if (q_in >= 12) m_err = 1;
      m_pv = (q_in <= 11);
      m_qr = int'(q_in);
    end
    started = 1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("seg", 32'(seg), 32'(m_seg));
      check("an", 32'(an), 32'(m_an));
      check("wrap_up", 32'(wrap_up), 32'(m_wu));
      check("wrap_dn", 32'(wrap_dn), 32'(m_wd));
      check("wraps", 32'(wraps), 32'(m_wraps));
      check("err", 32'(err), 32'(m_err));
      check("pulse_excl", 32'(wrap_up & wrap_dn), 32'd0);
    end
  end

  task automatic cyc(input logic [3:0] q, input logic ud, input logic rst);
    reset = rst; q_in = q; ud_in = ud;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  int n_up, n_dn, cnt;
  logic ud_r;

  initial begin
    reset = 1'b0; q_in = 4'd0; ud_in = 1'b1;
    @(negedge clk);

    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'd3);
    check("rst_wraps", 32'(wraps), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1);
      check("mux_phase", 32'(an), (i < 4) ? 32'd2 : 32'd1);
    end

    n_up = 0; n_dn = 0;
    for (int i = 0; i <= 14; i++) begin
      cyc(4'((i <= 11) ? i : 0), 1, 1);
      n_up += int'(wrap_up);
      n_dn += int'(wrap_dn);
    end
    check("up_pulses", 32'(n_up), 32'd1);
    check("up_no_dn", 32'(n_dn), 32'd0);
    check("up_wraps", 32'(wraps), 32'd1);

    cyc(0, 0, 1); cyc(11, 0, 1); cyc(10, 0, 1); cyc(10, 0, 1);
    check("dn_wraps", 32'(wraps), 32'd0);
    cyc(0, 0, 1); cyc(11, 0, 1); cyc(11, 0, 1);
    check("dn_underflow", 32'(wraps), 32'd15);

    cyc(11, 1, 1); cyc(0, 0, 1); cyc(11, 1, 1); cyc(11, 1, 1);
    check("wrong_dir_wraps", 32'(wraps), 32'd15);

    for (int i = 0; i < 12; i++) begin
      cyc(7, 1, 1);
      if (i >= 2) check(an == 2'b10 ? "q7_units" : "q7_tens", 32'(seg),
                        an == 2'b10 ? 32'(7'b1111000) : 32'(TENS0));
    end
    for (int i = 0; i < 12; i++) begin
      cyc(11, 1, 1);
      if (i >= 2) check("q11_glyph", 32'(seg), 32'(7'b1111001));
    end

    cyc(13, 1, 1);
    cyc(0, 1, 1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_dash", 32'(seg), 32'(7'b0111111));
    cyc(0, 1, 1);
    check("ill_no_wrap", 32'(wrap_up), 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1);
    check("err_sticky", 32'(err), 32'd1);
    cyc(0, 1, 0);
    check("err_cleared", 32'(err), 32'd0);

    cnt = 0; ud_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0) ud_r = ~ud_r;
      if (r < 2) begin
        cyc(4'(cnt), ud_r, 0);
      end else if (r < 7) begin
        cyc(4'($urandom_range(12, 15)), ud_r, 1);
      end else if (r < 14) begin
        cnt = int'($urandom_range(0, 11));
        cyc(4'(cnt), ud_r, 1);
      end else if (r < 24) begin
        cyc(4'(cnt), ud_r, 1);
      end else begin
        cnt = ud_r ? (cnt + 1) % 12 : (cnt + 11) % 12;
        cyc(4'(cnt), ud_r, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
